// File: rtl/fpu_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// fpu_add_sub_pkg
// Shared definitions for the floating-point add/sub path: the encoding of the
// normalizer control states, the layout of the raw adder mantissa word, and the
// all-ones exponent constant used for overflow saturation.
//
// Raw mantissa word layout (MantissaSize + 5 bits, offsets from bit 0):
//   [MantissaSize+4] carry   [MantissaSize+3] hidden
//   [MantissaSize+2:3] fraction   [2] guard   [1] round   [0] sticky
// -----------------------------------------------------------------------------
package fpu_add_sub_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] NORM_ENC  = 2'd1;
    localparam logic [1:0] ROUND_ENC = 2'd2;
    localparam logic [1:0] HOLD_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_NORM  = NORM_ENC,
        ST_ROUND = ROUND_ENC,
        ST_HOLD  = HOLD_ENC
    } norm_state_e;

    // Carry and hidden positions are MantissaSize plus these offsets.
    localparam int CARRY_OFS  = 4;
    localparam int HIDDEN_OFS = 3;
    localparam int FRAC_LSB   = 3;
    localparam int G_IDX      = 2;
    localparam int R_IDX      = 1;
    localparam int S_IDX      = 0;

    // Wide enough for any practical exponent width; sliced to ExponentSize.
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/mantissa_normalizer_if.sv
// -----------------------------------------------------------------------------
// mantissa_normalizer_if
// Handshake and data bundle of the mantissa normalizer.
//   slave  : view of the normalizer (consumes In_*, produces Out_* and flags)
//   master : view of the surrounding logic (produces In_*, consumes results)
// Signals:
//   In_Valid/In_Ready         input word handshake
//   In_Sign/In_Exponent/In_Mantissa   raw adder result and larger exponent
//   Out_Valid/Out_Ready       result handshake
//   Out_Sign/Out_Exponent/Out_Fraction, Zero/Overflow/Underflow   result
// -----------------------------------------------------------------------------
interface mantissa_normalizer_if #(
    parameter int ExponentSize = 8,
    parameter int MantissaSize = 23
);
    logic                      In_Valid;
    logic                      In_Ready;
    logic                      In_Sign;
    logic [ExponentSize-1:0]   In_Exponent;
    logic [MantissaSize+4:0]   In_Mantissa;
    logic                      Out_Valid;
    logic                      Out_Ready;
    logic                      Out_Sign;
    logic [ExponentSize-1:0]   Out_Exponent;
    logic [MantissaSize-1:0]   Out_Fraction;
    logic                      Zero;
    logic                      Overflow;
    logic                      Underflow;

    modport slave (
        input  In_Valid, In_Sign, In_Exponent, In_Mantissa, Out_Ready,
        output In_Ready, Out_Valid, Out_Sign, Out_Exponent, Out_Fraction,
               Zero, Overflow, Underflow
    );

    modport master (
        output In_Valid, In_Sign, In_Exponent, In_Mantissa, Out_Ready,
        input  In_Ready, Out_Valid, Out_Sign, Out_Exponent, Out_Fraction,
               Zero, Overflow, Underflow
    );
endinterface

// File: rtl/leading_zero_counter.sv
// -----------------------------------------------------------------------------
// leading_zero_counter
// Counts the zero bits above the most significant set bit of value_i.
// An all-zero input returns Width.
// Ports:
//   value_i  [Width-1:0]  word to scan (MSB first)
//   count_o  [CntW-1:0]   number of leading zeros
// -----------------------------------------------------------------------------
module leading_zero_counter #(
    parameter int Width = 27,
    parameter int CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] value_i,
    output logic [CntW-1:0]  count_o
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        count_o = CntW'(Width);
        for (int i = 0; i < Width; i++) begin
            if (value_i[i]) begin
                count_o = CntW'(Width - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mantissa_normalizer.sv
// -----------------------------------------------------------------------------
// mantissa_normalizer
// Normalize-and-round stage after the mantissa adder of the add/sub path.
// Takes the raw signed-magnitude sum and the larger operand's exponent,
// shifts the mantissa back to normalized position, adjusts the exponent,
// rounds to nearest-even and flags zero/overflow/underflow.
//
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    mantissa_normalizer_if.slave (In_* handshake/data, Out_* result)
//
// Build option:
//   MANTISSA_NORMALIZER_LZC_EN  defined: left shift done in one NORM cycle
//                               using a leading-zero counter (fixed latency).
//                               undefined: one bit of left shift per cycle.
//   Both builds give bit-identical results.
// -----------------------------------------------------------------------------
module mantissa_normalizer
    import fpu_add_sub_pkg::*;
#(
    parameter int ExponentSize = 8,
    parameter int MantissaSize = 23
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    mantissa_normalizer_if.slave bus
);

    localparam int MantW     = MantissaSize + 5;
    // One extra exponent bit so an increment past all-ones is visible.
    localparam int ExpW      = ExponentSize + 1;
    localparam int CarryIdx  = MantissaSize + CARRY_OFS;
    localparam int HiddenIdx = MantissaSize + HIDDEN_OFS;
    localparam logic [ExpW-1:0] ExpOnes = {1'b0, ALL_ONES[ExponentSize-1:0]};
    localparam logic [ExpW-1:0] ExpOne  = ExpW'(1);

    norm_state_e               state_q, state_d;
    logic                      sign_q, sign_d;
    logic [ExpW-1:0]           exp_q, exp_d;
    logic [MantW-1:0]          mant_q, mant_d;
    logic                      zero_q, zero_d;

    logic                      out_valid_q, out_valid_d;
    logic                      out_sign_q, out_sign_d;
    logic [ExponentSize-1:0]   out_exp_q, out_exp_d;
    logic [MantissaSize-1:0]   out_frac_q, out_frac_d;
    logic                      out_zero_q, out_zero_d;
    logic                      out_ovf_q, out_ovf_d;
    logic                      out_unf_q, out_unf_d;

    // {hidden,fraction} plus the nearest-even increment; MSB is the carry out.
    function automatic logic [MantissaSize+1:0] round_nearest_even(
        input logic [MantissaSize:0] sig,
        input logic                  g,
        input logic                  r,
        input logic                  s
    );
        logic inc;
        inc = g & (r | s | sig[0]);
        return {1'b0, sig} + {{(MantissaSize + 1){1'b0}}, inc};
    endfunction

    // Rounding datapath, consumed in ROUND.
    logic [MantissaSize+1:0]  rnd_sum;
    logic [ExpW-1:0]          rnd_exp;
    logic [MantissaSize-1:0]  rnd_frac;
    logic                     rnd_ovf;
    logic                     rnd_unf;

    always_comb begin
        rnd_sum  = round_nearest_even(mant_q[HiddenIdx:FRAC_LSB], mant_q[G_IDX],
                                      mant_q[R_IDX], mant_q[S_IDX]);
        rnd_exp  = exp_q;
        rnd_frac = rnd_sum[MantissaSize-1:0];
        if (rnd_sum[MantissaSize+1]) begin
            // 1.111..1 rounded up: renormalize right by one.
            rnd_frac = rnd_sum[MantissaSize:1];
            rnd_exp  = exp_q + ExpOne;
        end else if ((exp_q == '0) && rnd_sum[MantissaSize]) begin
            // Denormal rounded up into the hidden bit becomes the smallest normal.
            rnd_exp = ExpOne;
        end
        rnd_ovf = (rnd_exp >= ExpOnes);
        if (rnd_ovf) begin
            rnd_exp  = ExpOnes;
            rnd_frac = '0;
        end
        rnd_unf = (rnd_exp == '0) && (rnd_frac != '0);
    end

`ifdef MANTISSA_NORMALIZER_LZC_EN
    localparam int LzcW    = MantW - 1;
    localparam int LzcCntW = $clog2(LzcW + 1);

    logic [LzcCntW-1:0] lz_count;
    logic [ExpW-1:0]    lz_ext;
    logic [ExpW-1:0]    exp_room;
    logic [ExpW-1:0]    shift_amt;
    logic [MantW-1:0]   mant_shifted;

    // Scan from the hidden bit down (carry is handled before any left shift).
    leading_zero_counter #(
        .Width (LzcW)
    ) u_lzc (
        .value_i (mant_q[LzcW-1:0]),
        .count_o (lz_count)
    );

    // Shift no further than exponent 1; below that the result is denormal.
    always_comb begin
        lz_ext       = ExpW'(lz_count);
        exp_room     = (exp_q == '0) ? '0 : exp_q - ExpOne;
        shift_amt    = (lz_ext < exp_room) ? lz_ext : exp_room;
        mant_shifted = mant_q << shift_amt;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_frac_d  = out_frac_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.In_Valid) begin
                    sign_d  = bus.In_Sign;
                    exp_d   = {1'b0, bus.In_Exponent};
                    mant_d  = bus.In_Mantissa;
                    zero_d  = 1'b0;
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                if (mant_q[CarryIdx]) begin
                    // Right shift keeps the dropped bit alive in sticky.
                    mant_d  = {1'b0, mant_q[MantW-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + ExpOne;
                    state_d = ST_ROUND;
                end else if (mant_q == '0) begin
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    state_d = ST_ROUND;
                end else if (mant_q[HiddenIdx]) begin
                    state_d = ST_ROUND;
`ifdef MANTISSA_NORMALIZER_LZC_EN
                end else begin
                    mant_d  = mant_shifted;
                    exp_d   = mant_shifted[HiddenIdx] ? (exp_q - shift_amt) : '0;
                    state_d = ST_ROUND;
                end
`else
                end else if (exp_q <= ExpOne) begin
                    exp_d   = '0;
                    state_d = ST_ROUND;
                end else begin
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - ExpOne;
                end
`endif
            end

            ST_ROUND: begin
                out_valid_d = 1'b1;
                out_sign_d  = sign_q;
                out_exp_d   = rnd_exp[ExponentSize-1:0];
                out_frac_d  = rnd_frac;
                out_zero_d  = zero_q;
                out_ovf_d   = rnd_ovf;
                out_unf_d   = rnd_unf;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                if (bus.Out_Ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_frac_q  <= out_frac_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    // Ready depends on state alone: no path from In_Valid or Out_Ready.
    assign bus.In_Ready     = (state_q == ST_IDLE);
    assign bus.Out_Valid    = out_valid_q;
    assign bus.Out_Sign     = out_sign_q;
    assign bus.Out_Exponent = out_exp_q;
    assign bus.Out_Fraction = out_frac_q;
    assign bus.Zero         = out_zero_q;
    assign bus.Overflow     = out_ovf_q;
    assign bus.Underflow    = out_unf_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// -----------------------------------------------------------------------------
// tb_mantissa_normalizer
// Self-checking bench for mantissa_normalizer: directed cases, randomized words
// against a behavioural model, back-to-back handshake, backpressure and reset
// abort. Result words are packed as {sign, exponent, fraction, Z, O, U}.
// -----------------------------------------------------------------------------
module tb_mantissa_normalizer;

    localparam int ES = 8;
    localparam int MS = 23;
`ifdef MANTISSA_NORMALIZER_LZC_EN
    localparam bit LZC = 1'b1;
`else
    localparam bit LZC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mantissa_normalizer_if #(.ExponentSize(ES), .MantissaSize(MS)) bus ();

    mantissa_normalizer #(
        .ExponentSize (ES),
        .MantissaSize (MS)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural reference: normalize by leading-one position, then round.
    function automatic void ref_model(input logic s, input logic [7:0] ein,
                                      input logic [27:0] min,
                                      output int lat, output logic [34:0] res);
        int     e, msb, need, shifts;
        longint sig, keep, grs, frac;
        logic   z, o, u;
        e = ein; sig = longint'(min); z = 1'b0; shifts = 0;
        if (sig >= (64'sd1 << 27)) begin
            sig = (sig >> 1) | (sig & 1);
            e++;
        end else if (sig == 0) begin
            e = 0; z = 1'b1;
        end else begin
            msb = 0;
            for (int i = 0; i < 27; i++) if (sig[i]) msb = i;
            need = 26 - msb;
            if (need <= e - 1) shifts = need;
            else shifts = (e >= 1) ? e - 1 : 0;
            sig = sig << shifts;
            e = e - shifts;
            if (need > shifts) e = 0;
        end
        keep = sig >> 3;
        grs  = sig & 7;
        if (grs > 4 || (grs == 4 && keep[0])) keep++;
        if (keep == (64'sd1 << 24)) begin
            keep = keep >> 1; e++;
        end else if (e == 0 && keep >= (64'sd1 << 23)) begin
            e = 1;
        end
        frac = keep & ((64'sd1 << 23) - 1);
        o = 1'b0;
        if (e >= 255) begin e = 255; frac = 0; o = 1'b1; end
        u = (e == 0) && (frac != 0);
        res = {s, e[7:0], frac[22:0], z, o, u};
        lat = LZC ? 3 : 3 + shifts;
    endfunction

    function automatic logic [34:0] observed();
        return {bus.Out_Sign, bus.Out_Exponent, bus.Out_Fraction,
                bus.Zero, bus.Overflow, bus.Underflow};
    endfunction

    // Drives one word from IDLE, waits (bounded) for Out_Valid, captures the
    // result, optionally holds Out_Ready low, then completes the handshake.
    task automatic send_word(input logic s, input logic [7:0] e, input logic [27:0] m,
                             input int hold, output int lat, output logic [34:0] res);
        @(negedge clk);
        bus.In_Sign = s; bus.In_Exponent = e; bus.In_Mantissa = m; bus.In_Valid = 1'b1;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        lat = 1;
        while (bus.Out_Valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = observed();
        repeat (hold) @(posedge clk);
        @(negedge clk); bus.Out_Ready = 1'b1;
        @(posedge clk); #1; bus.Out_Ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.In_Valid = 1'b0; bus.In_Sign = 1'b0; bus.In_Exponent = '0;
        bus.In_Mantissa = '0; bus.Out_Ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (bus.In_Ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.In_Ready);
        end
        checks++;
        if (bus.Out_Valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.Out_Valid);
        end
        checks++;
        if (observed() !== 35'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        int lat; logic [34:0] res;
        send_word(1'b0, 8'd127, 28'h800_0000, 0, lat, res);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL carry_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== {1'b0, 8'd128, 23'd0, 3'b000}) begin
            failures++; $display("FAIL carry_result: got %h expected %h", res, {1'b0, 8'd128, 23'd0, 3'b000});
        end
    endtask

    task automatic test_cancel();
        int lat; logic [34:0] res;
        int exp_lat;
        exp_lat = LZC ? 3 : 6;
        send_word(1'b1, 8'd130, 28'h080_0000, 0, lat, res);
        checks++;
        if (lat !== exp_lat) begin failures++; $display("FAIL cancel_latency: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (res !== {1'b1, 8'd127, 23'd0, 3'b000}) begin
            failures++; $display("FAIL cancel_result: got %h expected %h", res, {1'b1, 8'd127, 23'd0, 3'b000});
        end
    endtask

    task automatic test_zero();
        int lat; logic [34:0] res;
        send_word(1'b0, 8'd100, 28'h000_0000, 0, lat, res);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL zero_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== {1'b0, 8'd0, 23'd0, 3'b100}) begin
            failures++; $display("FAIL zero_result: got %h expected %h", res, {1'b0, 8'd0, 23'd0, 3'b100});
        end
    endtask

    task automatic test_overflow();
        int lat; logic [34:0] res;
        // hidden=1, fraction all ones, G=1, R=S=0: tie with odd LSB rounds up.
        send_word(1'b0, 8'd254, 28'h7FF_FFFC, 0, lat, res);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL ovf_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== {1'b0, 8'd255, 23'd0, 3'b010}) begin
            failures++; $display("FAIL ovf_result: got %h expected %h", res, {1'b0, 8'd255, 23'd0, 3'b010});
        end
    endtask

    task automatic test_denormal();
        int lat; logic [34:0] res;
        int exp_lat;
        exp_lat = LZC ? 3 : 4;
        send_word(1'b0, 8'd2, 28'h100_0000, 0, lat, res);
        checks++;
        if (lat !== exp_lat) begin failures++; $display("FAIL denorm_latency: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (res !== {1'b0, 8'd0, 23'h400000, 3'b001}) begin
            failures++; $display("FAIL denorm_result: got %h expected %h", res, {1'b0, 8'd0, 23'h400000, 3'b001});
        end
    endtask

    task automatic test_random();
        int lat, exp_lat, sh;
        logic [34:0] res, exp_res;
        logic [27:0] m;
        logic [7:0]  e;
        logic        s;
        for (int n = 0; n < 200; n++) begin
            s  = 1'($urandom);
            e  = 8'($urandom_range(0, 255));
            m  = 28'($urandom);
            sh = $urandom_range(0, 28);
            m  = m >> sh;
            if ($urandom_range(0, 3) != 0) m[27] = 1'b0;
            ref_model(s, e, m, exp_lat, exp_res);
            send_word(s, e, m, $urandom_range(0, 3), lat, res);
            checks++;
            if (lat !== exp_lat) begin
                failures++;
                $display("FAIL rand_latency[%0d] e=%h m=%h: got %0d expected %0d", n, e, m, lat, exp_lat);
            end
            checks++;
            if (res !== exp_res) begin
                failures++;
                $display("FAIL rand_result[%0d] e=%h m=%h: got %h expected %h", n, e, m, res, exp_res);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, exp_lat, dummy;
        logic [34:0] exp_res, exp_a;
        ref_model(1'b0, 8'd127, 28'h800_0000, dummy, exp_a);
        ref_model(1'b1, 8'd90, 28'h020_0001, exp_lat, exp_res);
        @(negedge clk);
        bus.In_Sign = 1'b0; bus.In_Exponent = 8'd127; bus.In_Mantissa = 28'h800_0000;
        bus.In_Valid = 1'b1;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        lat = 1;
        while (bus.Out_Valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (observed() !== exp_a) begin
            failures++; $display("FAIL b2b_first: got %h expected %h", observed(), exp_a);
        end
        // Offer the next word on the same edge as the result handshake.
        @(negedge clk);
        bus.In_Sign = 1'b1; bus.In_Exponent = 8'd90; bus.In_Mantissa = 28'h020_0001;
        bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
        @(posedge clk); #1;
        bus.Out_Ready = 1'b0;
        checks++;
        if ({bus.In_Ready, bus.Out_Valid} !== 2'b10) begin
            failures++; $display("FAIL b2b_after_handshake: got rdy/vld=%b expected 10", {bus.In_Ready, bus.Out_Valid});
        end
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        checks++;
        if (bus.In_Ready !== 1'b0) begin
            failures++; $display("FAIL b2b_accept: got in_ready=%b expected 0", bus.In_Ready);
        end
        lat = 1;
        while (bus.Out_Valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== exp_lat) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (observed() !== exp_res) begin
            failures++; $display("FAIL b2b_second: got %h expected %h", observed(), exp_res);
        end
        @(negedge clk); bus.Out_Ready = 1'b1;
        @(posedge clk); #1; bus.Out_Ready = 1'b0;
    endtask

    task automatic test_backpressure_reset();
        int lat, bad;
        logic [34:0] exp_res;
        ref_model(1'b1, 8'd127, 28'h800_0000, lat, exp_res);
        @(negedge clk);
        bus.In_Sign = 1'b1; bus.In_Exponent = 8'd127; bus.In_Mantissa = 28'h800_0000;
        bus.In_Valid = 1'b1;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        lat = 1;
        while (bus.Out_Valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.In_Valid = 1'b1; bus.In_Exponent = 8'($urandom); bus.In_Mantissa = 28'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({bus.Out_Valid, bus.In_Ready, observed()} !== {2'b10, exp_res}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got vld/rdy/res=%b%b/%h expected 10/%h",
                         c, bus.Out_Valid, bus.In_Ready, observed(), exp_res);
            end
        end
        @(negedge clk); bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
        @(posedge clk); #1; bus.Out_Ready = 1'b0;
        // Long cancellation word, then reset while it is still normalizing.
        @(negedge clk);
        bus.In_Sign = 1'b0; bus.In_Exponent = 8'd200; bus.In_Mantissa = 28'h000_0008;
        bus.In_Valid = 1'b1;
        @(posedge clk); #1;
        bus.In_Valid = 1'b0;
        checks++;
        if (bus.In_Ready !== 1'b0) begin
            failures++; $display("FAIL norm_busy: got in_ready=%b expected 0", bus.In_Ready);
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Out_Valid, bus.In_Ready} !== 2'b01) begin
            failures++; $display("FAIL reset_abort: got vld/rdy=%b expected 01", {bus.Out_Valid, bus.In_Ready});
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.Out_Valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL reset_no_output: got %0d valid cycles expected 0", bad);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_carry();
        test_cancel();
        test_zero();
        test_overflow();
        test_denormal();
        test_random();
        test_back_to_back();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
